gbc_mbc5_mapper: RTL and testbench

//  Cartridge-side responder for the GamePak bus: emulates an MBC5 mapper when no physical cart is used.

---
 rtl/gbc_mapper_pkg.sv | 48 ++++
 rtl/gbc_mbc5_bank_regs.sv | 69 ++++++
 rtl/gbc_mbc5_mapper.sv | 138 +++++++++++++
 tb/tb_gbc_mbc5_mapper.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbc_mapper_pkg.sv
// Shared types for the MBC5 mapper: address regions, FSM states and bank-register storage.
package gbc_mapper_pkg;

  typedef enum logic [2:0] {
    ROM0,
    ROMX,
    REG_RAMEN,
    REG_ROMLO,
    REG_ROMHI,
    REG_RAMB,
    CRAM,
    UNMAPPED
  } MapperRegion;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} MapperState;

  typedef struct packed {
    logic       ram_enable;
    logic [8:0] rom_bank;
    logic [3:0] ram_bank;
  } MapperRegs;

  localparam MapperRegs  REGS_RESET = '{ram_enable: 1'b0, rom_bank: 9'h001, ram_bank: 4'h0};
  localparam logic [7:0] OPEN_BUS   = 8'hFF;

  // Only the top address nibble matters; writes below $8000 hit bank registers, reads hit ROM.
  function automatic MapperRegion region_of(input logic [3:0] nib, input logic wr);
    MapperRegion r;
    r = UNMAPPED;
    if (!nib[3]) begin
      if (!wr) begin
        r = nib[2] ? ROMX : ROM0;
      end else begin
        case (nib[2:0])
          3'b000, 3'b001: r = REG_RAMEN;
          3'b010:         r = REG_ROMLO;
          3'b011:         r = REG_ROMHI;
          3'b100, 3'b101: r = REG_RAMB;
          default:        r = UNMAPPED;
        endcase
      end
    end else if (nib[3:1] == 3'b101) begin
      r = CRAM;
    end
    return r;
  endfunction

endpackage

// File: rtl/gbc_mbc5_bank_regs.sv
// MBC5 bank registers and ROM/save-RAM address generation.
// Optional GBC_MBC5_RUMBLE_EN: RamBank[3] becomes the rumble drive and the RAM bank field shrinks to 3 bits.
module gbc_mbc5_bank_regs
  import gbc_mapper_pkg::*;
#(
  parameter int ROM_BANKS_LOG2 = 9,
  parameter int RAM_BANKS_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          wr_en,
  input  MapperRegion                   wr_region,
  input  logic [7:0]                    wr_data,
  input  logic [14:0]                   addr,
  output MapperRegs                     regs,
  output logic [14+ROM_BANKS_LOG2-1:0]  rom_address,
  output logic [13+RAM_BANKS_LOG2-1:0]  ram_address,
  output logic                          rumble
);

`ifdef GBC_MBC5_RUMBLE_EN
  localparam int RAM_SEL_BITS = (RAM_BANKS_LOG2 > 3) ? 3 : RAM_BANKS_LOG2;
`else
  localparam int RAM_SEL_BITS = RAM_BANKS_LOG2;
`endif
  localparam logic [3:0] RAM_MASK = 4'((1 << RAM_SEL_BITS) - 1);

  MapperRegs  regs_q, regs_d;
  logic       rumble_q, rumble_d;
  logic [8:0] rom_bank_sel;
  logic [3:0] ram_bank_sel;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      case (wr_region)
        REG_RAMEN: regs_d.ram_enable    = (wr_data[3:0] == 4'hA);
        REG_ROMLO: regs_d.rom_bank[7:0] = wr_data;
        REG_ROMHI: regs_d.rom_bank[8]   = wr_data[0];
        REG_RAMB:  regs_d.ram_bank      = wr_data[3:0];
        default:   ;
      endcase
    end
`ifdef GBC_MBC5_RUMBLE_EN
    rumble_d = regs_d.ram_bank[3];
`else
    rumble_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      regs_q   <= REGS_RESET;
      rumble_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      rumble_q <= rumble_d;
    end
  end

  // Bank 0 is a legal switchable bank; oversized bank numbers wrap by truncation.
  assign rom_bank_sel = addr[14] ? regs_q.rom_bank : 9'h000;
  assign ram_bank_sel = regs_q.ram_bank & RAM_MASK;
  assign rom_address  = {rom_bank_sel[ROM_BANKS_LOG2-1:0], addr[13:0]};
  assign ram_address  = {ram_bank_sel[RAM_BANKS_LOG2-1:0], addr[12:0]};
  assign regs         = regs_q;
  assign rumble       = rumble_q;

endmodule

// File: rtl/gbc_mbc5_mapper.sv
// MBC5 cartridge responder: bus handshake FSM in front of the ROM cache and save RAM.
// Build option GBC_MBC5_RUMBLE_EN enables the rumble motor output (handled in gbc_mbc5_bank_regs).
module gbc_mbc5_mapper
  import gbc_mapper_pkg::*;
#(
  parameter int ROM_BANKS_LOG2 = 9,
  parameter int RAM_BANKS_LOG2 = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          ClkEn,
  input  logic                          BusAccess,
  input  logic                          BusWrite,
  input  logic [15:0]                   BusAddress,
  input  logic [7:0]                    BusDin,
  output logic [7:0]                    BusDout,
  output logic                          BusReady,
  output logic                          BusDataReady,
  output logic                          RomAccess,
  output logic [14+ROM_BANKS_LOG2-1:0]  RomAddress,
  input  logic                          RomReady,
  input  logic                          RomDataReady,
  input  logic [7:0]                    RomDin,
  output logic                          RamAccess,
  output logic                          RamWrite,
  output logic [13+RAM_BANKS_LOG2-1:0]  RamAddress,
  output logic [7:0]                    RamDout,
  input  logic                          RamReady,
  input  logic                          RamDataReady,
  input  logic [7:0]                    RamDin,
  output logic                          Rumble
);

  MapperState  state_q, state_d;
  MapperRegion region;
  MapperRegs   regs;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  ram_dout_q, ram_dout_d, bus_dout_q, bus_dout_d;
  logic        is_ram_q, is_ram_d, ram_write_q, ram_write_d;
  logic        bus_ready_q, bus_data_ready_q, rom_access_q, ram_access_q;
  logic        reg_wr;

  always_comb begin
    region      = region_of(BusAddress[15:12], BusWrite);
    state_d     = state_q;
    addr_d      = addr_q;
    is_ram_d    = is_ram_q;
    ram_write_d = ram_write_q;
    ram_dout_d  = ram_dout_q;
    bus_dout_d  = bus_dout_q;
    reg_wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ClkEn && BusAccess) begin
          addr_d      = BusAddress[14:0];
          ram_dout_d  = BusDin;
          ram_write_d = 1'b0;
          is_ram_d    = 1'b0;
          bus_dout_d  = OPEN_BUS;
          state_d     = DONE;
          case (region)
            ROM0, ROMX: state_d = REQ;
            CRAM: begin
              if (regs.ram_enable) begin
                is_ram_d    = 1'b1;
                ram_write_d = BusWrite;
                state_d     = REQ;
              end
            end
            REG_RAMEN, REG_ROMLO, REG_ROMHI, REG_RAMB: reg_wr = 1'b1;
            default: ;
          endcase
        end
      end
      REQ: if (ClkEn && (is_ram_q ? RamReady : RomReady)) state_d = WAIT;
      WAIT: begin
        if (ClkEn && (is_ram_q ? RamDataReady : RomDataReady)) begin
          state_d = DONE;
          if (!ram_write_q) bus_dout_d = is_ram_q ? RamDin : RomDin;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      is_ram_q         <= 1'b0;
      ram_write_q      <= 1'b0;
      ram_dout_q       <= 8'h00;
      bus_dout_q       <= OPEN_BUS;
      bus_ready_q      <= 1'b1;
      bus_data_ready_q <= 1'b0;
      rom_access_q     <= 1'b0;
      ram_access_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      is_ram_q         <= is_ram_d;
      ram_write_q      <= ram_write_d;
      ram_dout_q       <= ram_dout_d;
      bus_dout_q       <= bus_dout_d;
      bus_ready_q      <= (state_d == IDLE);
      bus_data_ready_q <= (state_d == DONE);
      rom_access_q     <= (state_d == REQ) && !is_ram_d;
      ram_access_q     <= (state_d == REQ) && is_ram_d;
    end
  end

  gbc_mbc5_bank_regs #(
    .ROM_BANKS_LOG2 (ROM_BANKS_LOG2),
    .RAM_BANKS_LOG2 (RAM_BANKS_LOG2)
  ) u_bank_regs (
    .clk         (Clk),
    .srst        (Reset),
    .wr_en       (reg_wr),
    .wr_region   (region),
    .wr_data     (BusDin),
    .addr        (addr_q),
    .regs        (regs),
    .rom_address (RomAddress),
    .ram_address (RamAddress),
    .rumble      (Rumble)
  );

  assign BusDout      = bus_dout_q;
  assign BusReady     = bus_ready_q;
  assign BusDataReady = bus_data_ready_q;
  assign RomAccess    = rom_access_q;
  assign RamAccess    = ram_access_q;
  assign RamWrite     = ram_write_q && ram_access_q;
  assign RamDout      = ram_dout_q;

endmodule

// File: tb/tb_gbc_mbc5_mapper.sv
// Bench for gbc_mbc5_mapper: ROM/save-RAM device responders plus a bank-switching reference model.
module tb_gbc_mbc5_mapper;
  localparam int ROM_LOG2 = 9;
  localparam int RAM_LOG2 = 4;
`ifdef GBC_MBC5_RUMBLE_EN
  localparam bit RUMBLE_EN = 1'b1;
`else
  localparam bit RUMBLE_EN = 1'b0;
`endif

  logic Clk = 1'b0, Reset = 1'b1, ClkEn = 1'b1, BusAccess = 1'b0, BusWrite = 1'b0;
  logic [15:0] BusAddress = 16'h0;
  logic [7:0]  BusDin = 8'h0, BusDout;
  logic BusReady, BusDataReady, RomAccess, RamAccess, RamWrite, Rumble;
  logic [14+ROM_LOG2-1:0] RomAddress;
  logic [13+RAM_LOG2-1:0] RamAddress;
  logic [7:0] RamDout;
  logic RomReady = 1'b0, RomDataReady = 1'b0, RamReady = 1'b0, RamDataReady = 1'b0;
  logic [7:0] RomDin = 8'h0, RamDin = 8'h0;

  int tests_run = 0, tests_failed = 0;
  int rom_ready_delay = 0, rom_data_delay = 0, ram_ready_delay = 0, ram_data_delay = 0;
  int rom_reqs = 0, ram_reqs = 0, rom_last_addr = -1, ram_last_addr = -1;
  int rom_phase = 0, rom_cnt = 0, ram_phase = 0, ram_cnt = 0;
  bit ram_last_wr = 1'b0;
  logic [7:0] ram_lat_data = 8'h0;
  logic [7:0] dev_sram [int];
  bit m_ram_en;
  int m_rom_bank, m_ram_bank;
  logic [7:0] m_sram [int];

  gbc_mbc5_mapper #(.ROM_BANKS_LOG2(ROM_LOG2), .RAM_BANKS_LOG2(RAM_LOG2)) dut (
    .Clk(Clk), .Reset(Reset), .ClkEn(ClkEn), .BusAccess(BusAccess), .BusWrite(BusWrite),
    .BusAddress(BusAddress), .BusDin(BusDin), .BusDout(BusDout), .BusReady(BusReady),
    .BusDataReady(BusDataReady), .RomAccess(RomAccess), .RomAddress(RomAddress),
    .RomReady(RomReady), .RomDataReady(RomDataReady), .RomDin(RomDin),
    .RamAccess(RamAccess), .RamWrite(RamWrite), .RamAddress(RamAddress), .RamDout(RamDout),
    .RamReady(RamReady), .RamDataReady(RamDataReady), .RamDin(RamDin), .Rumble(Rumble)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] rom_byte(input int a);
    return 8'((a * 29) ^ (a >> 9));
  endfunction

  // ROM cache and save RAM devices with programmable accept/completion delays.
  always @(negedge Clk) begin
    RomReady = 1'b0; RomDataReady = 1'b0; RamReady = 1'b0; RamDataReady = 1'b0;
    if (Reset) begin
      rom_phase = 0; rom_cnt = 0; ram_phase = 0; ram_cnt = 0;
    end else begin
      if (rom_phase == 1) begin
        if (rom_cnt >= rom_data_delay) begin
          RomDataReady = 1'b1; RomDin = rom_byte(rom_last_addr); rom_phase = 0; rom_cnt = 0;
        end else rom_cnt++;
      end else if (RomAccess === 1'b1) begin
        if (rom_cnt >= rom_ready_delay) begin
          RomReady = 1'b1; rom_last_addr = int'(RomAddress); rom_phase = 1; rom_cnt = 0; rom_reqs++;
        end else rom_cnt++;
      end
      if (ram_phase == 1) begin
        if (ram_cnt >= ram_data_delay) begin
          RamDataReady = 1'b1; ram_phase = 0; ram_cnt = 0;
          if (ram_last_wr) dev_sram[ram_last_addr] = ram_lat_data;
          else RamDin = dev_sram.exists(ram_last_addr) ? dev_sram[ram_last_addr] : 8'h00;
        end else ram_cnt++;
      end else if (RamAccess === 1'b1) begin
        if (ram_cnt >= ram_ready_delay) begin
          RamReady = 1'b1; ram_last_addr = int'(RamAddress); ram_last_wr = RamWrite;
          ram_lat_data = RamDout; ram_phase = 1; ram_cnt = 0; ram_reqs++;
        end else ram_cnt++;
      end
    end
  end

  function automatic void model_reset();
    m_ram_en = 1'b0; m_rom_bank = 1; m_ram_bank = 0;
  endfunction

  function automatic int ram_bank_eff();
    int b;
    b = RUMBLE_EN ? (m_ram_bank % 8) : (m_ram_bank % 16);
    return b % (1 << RAM_LOG2);
  endfunction

  // Reference behaviour of one bus transaction: updates the model and predicts the response.
  task automatic model_access(input bit wr, input int a, input int d, output logic [7:0] exp_data,
                              output int exp_lat, output int exp_rom, output int exp_ram, output int exp_addr);
    exp_data = 8'hFF; exp_lat = 1; exp_rom = 0; exp_ram = 0; exp_addr = -1;
    if (a < 'h8000) begin
      if (wr) begin
        if (a < 'h2000) m_ram_en = ((d % 16) == 10);
        else if (a < 'h3000) m_rom_bank = (m_rom_bank / 256) * 256 + (d % 256);
        else if (a < 'h4000) m_rom_bank = (m_rom_bank % 256) + (d % 2) * 256;
        else if (a < 'h6000) m_ram_bank = d % 16;
      end else begin
        exp_rom  = 1;
        exp_addr = (a < 'h4000) ? a : (m_rom_bank % (1 << ROM_LOG2)) * 16384 + (a % 16384);
        exp_data = rom_byte(exp_addr);
        exp_lat  = 3 + rom_ready_delay + rom_data_delay;
      end
    end else if (a >= 'hA000 && a < 'hC000 && m_ram_en) begin
      exp_ram  = 1;
      exp_addr = ram_bank_eff() * 8192 + (a % 8192);
      exp_lat  = 3 + ram_ready_delay + ram_data_delay;
      if (wr) m_sram[exp_addr] = 8'(d);
      else exp_data = m_sram.exists(exp_addr) ? m_sram[exp_addr] : 8'h00;
    end
  endtask

  task automatic do_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                           output logic [7:0] rdata, output int lat, output int pulses);
    int guard;
    @(negedge Clk);
    guard = 0;
    while (BusReady !== 1'b1 && guard < 200) begin @(negedge Clk); guard++; end
    BusAccess = 1'b1; BusWrite = wr; BusAddress = a; BusDin = d;
    @(posedge Clk); #1;
    BusAccess = 1'b0;
    lat = 1; pulses = 0; rdata = 8'h00; guard = 0;
    while (BusDataReady !== 1'b1 && guard < 200) begin @(posedge Clk); #1; lat++; guard++; end
    if (BusDataReady !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL access_timeout addr=%h: no BusDataReady within 200 cycles", a);
    end else begin
      rdata = BusDout; pulses = 1;
    end
    @(posedge Clk); #1;
    if (BusDataReady === 1'b1) pulses++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    tests_run++; if (BusReady !== 1'b1) begin tests_failed++; $display("FAIL reset_busready got=%b exp=1", BusReady); end
    tests_run++; if (BusDataReady !== 1'b0) begin tests_failed++; $display("FAIL reset_datardy got=%b exp=0", BusDataReady); end
    tests_run++; if (BusDout !== 8'hFF) begin tests_failed++; $display("FAIL reset_dout got=%h exp=ff", BusDout); end
    tests_run++; if ({RomAccess, RamAccess, RamWrite} !== 3'b000) begin tests_failed++; $display("FAIL reset_strobes got=%b exp=000", {RomAccess, RamAccess, RamWrite}); end
    tests_run++; if (Rumble !== 1'b0) begin tests_failed++; $display("FAIL reset_rumble got=%b exp=0", Rumble); end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_rom0_read();
    logic [7:0] rd, ed; int lat, pulses, el, er, eram, ea, r0;
    r0 = rom_reqs;
    model_access(1'b0, 'h0150, 0, ed, el, er, eram, ea);
    do_access(1'b0, 16'h0150, 8'h00, rd, lat, pulses);
    tests_run++; if (rom_last_addr !== 'h0150) begin tests_failed++; $display("FAIL rom0_addr got=%h exp=000150", rom_last_addr); end
    tests_run++; if (rd !== ed) begin tests_failed++; $display("FAIL rom0_data got=%h exp=%h", rd, ed); end
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL rom0_latency got=%0d exp=3", lat); end
    tests_run++; if (pulses !== 1 || rom_reqs - r0 !== 1) begin tests_failed++; $display("FAIL rom0_pulses got=%0d/%0d exp=1/1", pulses, rom_reqs - r0); end
    $display("[TB] read $0150 -> rom %h data %h lat %0d", rom_last_addr, rd, lat);
  endtask

  task automatic test_bank_switch();
    logic [7:0] rd, ed; int lat, pulses, el, er, eram, ea, r0;
    r0 = rom_reqs;
    model_access(1'b1, 'h2000, 'h05, ed, el, er, eram, ea);
    do_access(1'b1, 16'h2000, 8'h05, rd, lat, pulses);
    tests_run++; if (lat !== 1 || pulses !== 1) begin tests_failed++; $display("FAIL romlo_retire got lat=%0d pulses=%0d exp 1/1", lat, pulses); end
    model_access(1'b1, 'h3000, 'h01, ed, el, er, eram, ea);
    do_access(1'b1, 16'h3000, 8'h01, rd, lat, pulses);
    tests_run++; if (rom_reqs !== r0) begin tests_failed++; $display("FAIL regwr_no_rom got=%0d exp=%0d", rom_reqs, r0); end
    model_access(1'b0, 'h4123, 0, ed, el, er, eram, ea);
    do_access(1'b0, 16'h4123, 8'h00, rd, lat, pulses);
    tests_run++; if (rom_last_addr !== 'h414123) begin tests_failed++; $display("FAIL romx_addr got=%h exp=414123", rom_last_addr); end
    tests_run++; if (rd !== ed) begin tests_failed++; $display("FAIL romx_data got=%h exp=%h", rd, ed); end
    $display("[TB] bank 105 read $4123 -> rom %h data %h", rom_last_addr, rd);
  endtask

  task automatic test_cram();
    logic [7:0] rd, ed; int lat, pulses, el, er, eram, ea, q0;
    q0 = ram_reqs;
    model_access(1'b0, 'hA000, 0, ed, el, er, eram, ea);
    do_access(1'b0, 16'hA000, 8'h00, rd, lat, pulses);
    tests_run++; if (rd !== 8'hFF || lat !== 1) begin tests_failed++; $display("FAIL cram_off_read got=%h lat=%0d exp=ff lat=1", rd, lat); end
    model_access(1'b1, 'hB002, 'h99, ed, el, er, eram, ea);
    do_access(1'b1, 16'hB002, 8'h99, rd, lat, pulses);
    tests_run++; if (ram_reqs !== q0) begin tests_failed++; $display("FAIL cram_off_noaccess got=%0d exp=%0d", ram_reqs, q0); end
    model_access(1'b1, 'h0000, 'h0A, ed, el, er, eram, ea);
    do_access(1'b1, 16'h0000, 8'h0A, rd, lat, pulses);
    model_access(1'b1, 'h4000, 'h03, ed, el, er, eram, ea);
    do_access(1'b1, 16'h4000, 8'h03, rd, lat, pulses);
    model_access(1'b1, 'hB001, 'h5A, ed, el, er, eram, ea);
    do_access(1'b1, 16'hB001, 8'h5A, rd, lat, pulses);
    tests_run++; if (ram_last_addr !== 'h07001 || ram_last_wr !== 1'b1) begin tests_failed++; $display("FAIL cram_wr_addr got=%h wr=%b exp=07001 wr=1", ram_last_addr, ram_last_wr); end
    model_access(1'b0, 'hB001, 0, ed, el, er, eram, ea);
    do_access(1'b0, 16'hB001, 8'h00, rd, lat, pulses);
    tests_run++; if (rd !== 8'h5A || ram_last_wr !== 1'b0) begin tests_failed++; $display("FAIL cram_readback got=%h wr=%b exp=5a wr=0", rd, ram_last_wr); end
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL cram_latency got=%0d exp=3", lat); end
    model_access(1'b0, 'hB002, 0, ed, el, er, eram, ea);
    do_access(1'b0, 16'hB002, 8'h00, rd, lat, pulses);
    tests_run++; if (rd !== ed) begin tests_failed++; $display("FAIL cram_dropped_write got=%h exp=%h", rd, ed); end
    $display("[TB] cram bank 3 $B001 -> ram %h data %h", ram_last_addr, rd);
  endtask

  task automatic test_clken();
    int r0;
    r0 = rom_reqs;
    @(negedge Clk);
    ClkEn = 1'b0; BusAccess = 1'b1; BusWrite = 1'b0; BusAddress = 16'h0100;
    repeat (3) @(negedge Clk);
    BusAccess = 1'b0; ClkEn = 1'b1;
    repeat (4) @(negedge Clk);
    tests_run++; if (rom_reqs !== r0 || BusReady !== 1'b1) begin tests_failed++; $display("FAIL clken_gate got reqs=%0d ready=%b exp reqs=%0d ready=1", rom_reqs, BusReady, r0); end
    $display("[TB] access with ClkEn low ignored");
  endtask

  task automatic test_stall();
    logic [7:0] ed; int el, er, eram, ea, r0, pulses, first;
    rom_ready_delay = 5; rom_data_delay = 0;
    r0 = rom_reqs; pulses = 0; first = -1;
    model_access(1'b0, 'h4555, 0, ed, el, er, eram, ea);
    @(negedge Clk);
    BusAccess = 1'b1; BusWrite = 1'b0; BusAddress = 16'h4555;
    @(posedge Clk); #1;
    BusAccess = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (i < 5) begin
        tests_run++; if (RomAccess !== 1'b1 || BusReady !== 1'b0) begin tests_failed++; $display("FAIL stall_hold cyc=%0d got acc=%b rdy=%b exp acc=1 rdy=0", i, RomAccess, BusReady); end
      end
      if (i == 2) begin BusAccess = 1'b1; BusAddress = 16'h0200; end
      if (i == 3) BusAccess = 1'b0;
      if (BusDataReady === 1'b1) begin pulses++; if (first < 0) first = i; end
    end
    tests_run++; if (pulses !== 1 || first !== el - 1) begin tests_failed++; $display("FAIL stall_done got pulses=%0d at=%0d exp 1 at %0d", pulses, first, el - 1); end
    tests_run++; if (rom_reqs - r0 !== 1 || rom_last_addr !== ea) begin tests_failed++; $display("FAIL stall_single got reqs=%0d addr=%h exp 1 addr=%h", rom_reqs - r0, rom_last_addr, ea); end
    rom_ready_delay = 0;
    $display("[TB] stalled read $4555 retired once, latency %0d", first + 1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd, ed; int lat, pulses, el, er, eram, ea, guard, seen;
    rom_data_delay = 6; guard = 0; seen = 0;
    @(negedge Clk);
    BusAccess = 1'b1; BusWrite = 1'b0; BusAddress = 16'h0300;
    @(posedge Clk); #1;
    BusAccess = 1'b0;
    while (rom_phase != 1 && guard < 50) begin @(posedge Clk); #1; guard++; end
    tests_run++; if (rom_phase != 1) begin tests_failed++; $display("FAIL midreset_reach_wait got phase=%0d exp=1", rom_phase); end
    Reset = 1'b1;
    @(posedge Clk); #1;
    tests_run++; if ({BusReady, BusDataReady, RomAccess, RamAccess, Rumble} !== 5'b10000 || BusDout !== 8'hFF) begin
      tests_failed++; $display("FAIL midreset_outputs got=%b dout=%h exp=10000 dout=ff", {BusReady, BusDataReady, RomAccess, RamAccess, Rumble}, BusDout); end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    rom_data_delay = 0;
    for (int i = 0; i < 10; i++) begin @(negedge Clk); if (BusDataReady === 1'b1) seen++; end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL midreset_no_pulse got=%0d exp=0", seen); end
    model_access(1'b0, 'h4000, 0, ed, el, er, eram, ea);
    do_access(1'b0, 16'h4000, 8'h00, rd, lat, pulses);
    tests_run++; if (rom_last_addr !== 'h004000 || rd !== ed) begin tests_failed++; $display("FAIL midreset_bank1 got=%h data=%h exp=004000 data=%h", rom_last_addr, rd, ed); end
    $display("[TB] reset in WAIT, then $4000 -> rom %h", rom_last_addr);
  endtask

  task automatic test_rumble();
    logic [7:0] rd, ed; int lat, pulses, el, er, eram, ea;
    model_access(1'b1, 'h0000, 'h0A, ed, el, er, eram, ea);
    do_access(1'b1, 16'h0000, 8'h0A, rd, lat, pulses);
    model_access(1'b1, 'h4000, 'h0B, ed, el, er, eram, ea);
    do_access(1'b1, 16'h4000, 8'h0B, rd, lat, pulses);
    tests_run++; if (Rumble !== RUMBLE_EN) begin tests_failed++; $display("FAIL rumble_out got=%b exp=%b", Rumble, RUMBLE_EN); end
    model_access(1'b1, 'hA005, 'h77, ed, el, er, eram, ea);
    do_access(1'b1, 16'hA005, 8'h77, rd, lat, pulses);
    tests_run++; if (ram_last_addr !== (RUMBLE_EN ? 'h06005 : 'h16005)) begin tests_failed++; $display("FAIL rumble_rambank got=%h exp=%h", ram_last_addr, RUMBLE_EN ? 'h06005 : 'h16005); end
    $display("[TB] $4000<=0b: rumble %b ram %h", Rumble, ram_last_addr);
  endtask

  task automatic test_random();
    logic [7:0] rd, ed, d; int lat, pulses, el, er, eram, ea, r0, q0, a, kind; bit wr;
    for (int n = 0; n < 80; n++) begin
      rom_ready_delay = $urandom_range(0, 3); rom_data_delay = $urandom_range(0, 3);
      ram_ready_delay = $urandom_range(0, 3); ram_data_delay = $urandom_range(0, 3);
      kind = $urandom_range(0, 4); d = 8'($urandom); wr = 1'b0;
      case (kind)
        0: a = $urandom_range(0, 'h7FFF);
        1: begin a = $urandom_range(0, 'h7FFF); wr = 1'b1; if (a < 'h2000 && $urandom_range(0, 1) == 1) d = 8'h0A; end
        2: a = 'hA000 + $urandom_range(0, 15) * 'h211;
        3: begin a = 'hA000 + $urandom_range(0, 15) * 'h211; wr = 1'b1; end
        default: begin a = ($urandom_range(0, 1) == 1) ? $urandom_range('h8000, 'h9FFF) : $urandom_range('hC000, 'hFFFF); wr = 1'($urandom); end
      endcase
      r0 = rom_reqs; q0 = ram_reqs;
      model_access(wr, a, int'(d), ed, el, er, eram, ea);
      do_access(wr, 16'(a), d, rd, lat, pulses);
      tests_run++; if (lat !== el || pulses !== 1) begin tests_failed++; $display("FAIL rand%0d_timing a=%h got lat=%0d pulses=%0d exp lat=%0d pulses=1", n, a, lat, pulses, el); end
      tests_run++; if (rom_reqs - r0 !== er || ram_reqs - q0 !== eram) begin tests_failed++; $display("FAIL rand%0d_reqs a=%h got rom=%0d ram=%0d exp rom=%0d ram=%0d", n, a, rom_reqs - r0, ram_reqs - q0, er, eram); end
      if (!wr) begin
        tests_run++; if (rd !== ed) begin tests_failed++; $display("FAIL rand%0d_data a=%h got=%h exp=%h", n, a, rd, ed); end
      end
      if (er == 1 || eram == 1) begin
        tests_run++; if ((er == 1 ? rom_last_addr : ram_last_addr) !== ea) begin tests_failed++; $display("FAIL rand%0d_addr a=%h got=%h exp=%h", n, a, er == 1 ? rom_last_addr : ram_last_addr, ea); end
      end
      tests_run++; if (Rumble !== (RUMBLE_EN && m_ram_bank >= 8)) begin tests_failed++; $display("FAIL rand%0d_rumble got=%b exp=%b", n, Rumble, RUMBLE_EN && m_ram_bank >= 8); end
      $display("[TB] rand %0d %s a=%h d=%h -> rd=%h lat=%0d", n, wr ? "wr" : "rd", a, d, rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_rom0_read();
    test_bank_switch();
    test_cram();
    test_clken();
    test_stall();
    test_reset_mid();
    test_rumble();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
